controller_poller: RTL and testbench
====================================

Name: controller_poller

Overview:
- Polls an NES-style serial game pad and publishes a debounced-by-frame button word to sys_io. It sits directly upstream of sys_io and drives the pad's latch and clock lines.
- Each transaction latches the pad, shifts 8 bits in over chip_data_raw, and reports the new state, newly-pressed edges and a one-cycle valid strobe.
- Transactions run on a free-running poll timer or on request.

Parameters:
- HALF_CYCLES, 600: cycles per half clock phase (6 us at 100 MHz); must be >= 4.
- POLL_CYCLES, 1666666: cycles between timer-triggered polls (60 Hz); must be > 18*HALF_CYCLES + 2.
- NUM_BUTTONS, 8: bits shifted per transaction.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- chip_data_raw  input  1  pad serial data; asynchronous, active-low
- force_poll_in  input  1  request an immediate poll
- chip_latch_out  output  1  pad latch
- chip_clk_out  output  1  pad shift clock; idles low
- buttons_out  output  NUM_BUTTONS  current state, 1 = pressed
- pressed_out  output  NUM_BUTTONS  rising edges vs previous poll; valid only with valid_out
- valid_out  output  1  one-cycle strobe, new sample published
- busy_out  output  1  transaction in progress

Behaviour:
- Reset values:
  - All outputs are 0.
  - The poll timer is 0, the FSM is in IDLE, and the shift register and 2-flop synchronizer are cleared.
- Synchronizer:
  - chip_data_raw passes through 2 flops (sync_data); the bit is inverted at sampling.
- Poll timer:
  - Counts 0..POLL_CYCLES-1 and wraps continuously, including during transactions.
  - Trigger = (timer == POLL_CYCLES-1) OR force_poll_in, evaluated only in IDLE.
  - Triggers arriving while busy are dropped, not queued.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE. A phase counter and a 3-bit bit index drive the transitions.
  - IDLE: on trigger, go to LATCH next cycle, with phase=0 and bit index=0.
  - LATCH: chip_latch_out=1 for exactly 2*HALF_CYCLES cycles, then go to LOW.
  - LOW: chip_clk_out=0 for HALF_CYCLES cycles. On the last LOW cycle, shift_reg[bit index] <= ~sync_data. Then go to HIGH.
  - HIGH: chip_clk_out=1 for HALF_CYCLES cycles. Then increment bit index; go to LOW, or to DONE if bit index was NUM_BUTTONS-1.
  - DONE: lasts one cycle.
    - valid_out=1.
    - buttons_out <= shift_reg.
    - pressed_out <= shift_reg & ~buttons_out (uses the old buttons_out).
    - Next state is IDLE.
- Cycle numbering: the first LATCH cycle is cycle 0.
  - valid_out is high on cycle 18*HALF_CYCLES.
  - busy_out is high from cycle 0 through cycle 18*HALF_CYCLES inclusive.
- Output timing:
  - chip_latch_out and chip_clk_out are registered and glitch-free.
  - 8 full clock pulses are issued; the final pulse is harmless to the pad.
- pressed_out holds its value until the next DONE; consumers qualify it with valid_out.
- buttons_out is stable between DONE cycles.
- Bit order: bit0=A, 1=B, 2=SELECT, 3=START, 4=UP, 5=DOWN, 6=LEFT, 7=RIGHT.
- Reset mid-transaction:
  - Abort immediately; outputs return to 0 the following cycle.
  - No valid_out is produced; the next poll starts from IDLE.
- Simultaneous timer wrap and force_poll_in in IDLE: a single transaction starts.
- force_poll_in held high continuously: back-to-back transactions with exactly 1 IDLE cycle between DONE and the next LATCH.
- Width rule: phase counter width = $clog2(2*HALF_CYCLES); timer width = $clog2(POLL_CYCLES).

Decomposition:
- Package controller_pkg holds:
  - NUM_BUTTONS
  - button index constants BTN_A..BTN_RIGHT
  - the FSM state enum poll_state_t
- One natural sub-module: sync_2ff (a generic 2-flop synchronizer), reusable elsewhere in sys_io.
- Everything else is single-module.

Test Plan:
All scenarios use HALF_CYCLES=4 and POLL_CYCLES=200 (a transaction is 72 cycles).
- Reset release, data held high (no buttons):
  - The first transaction starts when the timer reaches 199.
  - Latch is high for 8 cycles, followed by 8 clock pulses of 4 low/4 high.
  - valid_out pulses on cycle 72 with buttons_out=8'h00 and pressed_out=8'h00.
- Pad model presenting A+START+LEFT (bits 0,3,6 low on the wire):
  - buttons_out=8'h49 and pressed_out=8'h49.
  - A second identical poll gives buttons_out=8'h49 and pressed_out=8'h00.
- Change from 8'h49 to UP only:
  - buttons_out=8'h10 and pressed_out=8'h10; released bits do not appear in pressed_out.
- force_poll_in pulsed in IDLE at timer=50:
  - LATCH starts the next cycle and valid_out follows 72 cycles later.
  - A second force_poll_in pulsed mid-transaction is ignored: exactly one valid_out results.
- rst_in asserted during the LOW phase of bit 3:
  - The next cycle has latch=0, clk=0, busy_out=0 and buttons_out=0.
  - No valid_out occurs until a fresh poll completes.
- force_poll_in held high for 300 cycles:
  - valid_out strobes are exactly 74 cycles apart.
  - chip_clk_out never exceeds 4 consecutive high cycles.

Source files
------------

// File: rtl/controller_poller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg
// Shared definitions for the NES-style game pad poller and its consumers in
// sys_io: the width of the button word, the bit position of each button
// and the state encoding of the polling FSM.
// ---------------------------------------------------------------------------
package controller_pkg;

    // Number of bits shifted out of the pad on every transaction
    localparam int NUM_BUTTONS = 8;

    // Bit positions inside the published button word (1 = pressed)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Polling FSM states
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } poll_state_t;

endpackage

// File: rtl/controller_poller_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for bringing asynchronous signals into the
// clk_i domain. Both stages clear on a synchronous active-high reset.
//
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset
//   d_i    - asynchronous input
//   q_o    - synchronized output, two cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // The first stage may go metastable; the second stage gives it a full
    // cycle to resolve before anything downstream looks at the value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/controller_poller.sv
// ---------------------------------------------------------------------------
// controller_poller
// Polls an NES-style serial game pad and publishes one button word per
// transaction. A transaction pulses the pad latch for two half periods,
// then issues NUM_BUTTONS clock pulses (low half, high half), sampling the
// active-low serial data at the end of each low half. The result is
// published in a single DONE cycle together with the newly-pressed edges.
// Transactions start from a free-running poll timer or on force_poll_in.
//
// Ports:
//   clk_in          - system clock
//   rst_in          - synchronous active-high reset
//   chip_data_raw   - pad serial data, asynchronous, active-low
//   force_poll_in   - request an immediate poll (ignored while busy)
//   chip_latch_out  - pad latch, registered
//   chip_clk_out    - pad shift clock, registered, idles low
//   buttons_out     - current button state, 1 = pressed
//   pressed_out     - buttons newly pressed since the previous poll;
//                     qualify with valid_out
//   valid_out       - one-cycle strobe when a new sample is published
//   busy_out        - a transaction is in progress
// ---------------------------------------------------------------------------
module controller_poller
    import controller_pkg::*;
#(
    parameter int HALF_CYCLES = 600,
    parameter int POLL_CYCLES = 1666666
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   chip_data_raw,
    input  logic                   force_poll_in,
    output logic                   chip_latch_out,
    output logic                   chip_clk_out,
    output logic [NUM_BUTTONS-1:0] buttons_out,
    output logic [NUM_BUTTONS-1:0] pressed_out,
    output logic                   valid_out,
    output logic                   busy_out
);

    localparam int PHASE_W = $clog2(2 * HALF_CYCLES);
    localparam int TIMER_W = $clog2(POLL_CYCLES);

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_CYCLES - 1);
    localparam logic [2:0]         LAST_BIT   = 3'(NUM_BUTTONS - 1);

    poll_state_t            state_q, state_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [2:0]             bit_q, bit_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [NUM_BUTTONS-1:0] shift_q, shift_d;
    logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
    logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
    logic                   latch_q, latch_d;
    logic                   clk_q, clk_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   sync_data;
    logic                   trigger;

    // The pad data line is asynchronous to clk_in, so it is synchronized
    // before the FSM samples it.
    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .d_i   (chip_data_raw),
        .q_o   (sync_data)
    );

    // The poll timer runs continuously, even during transactions, so the
    // poll rate stays locked to POLL_CYCLES regardless of forced polls.
    always_comb begin
        timer_d = timer_q + TIMER_W'(1);
        if (timer_q == TIMER_LAST) begin
            timer_d = '0;
        end
    end

    // A wrap and a force request in the same cycle still start only one
    // transaction because the trigger is only acted on in IDLE.
    assign trigger = (timer_q == TIMER_LAST) || force_poll_in;

    // Next-state logic. The phase counter restarts on every state change;
    // the sampled bit is captured on the last LOW cycle so the pad data has
    // had the whole low half to settle through the synchronizer. The result
    // is published on the transition into DONE so buttons_out and
    // pressed_out line up with the valid_out strobe.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + PHASE_W'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        pressed_d = pressed_q;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (trigger) begin
                    state_d = LATCH;
                    bit_d   = '0;
                end
            end
            LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d = LOW;
                    phase_d = '0;
                end
            end
            LOW: begin
                if (phase_q == HALF_LAST) begin
                    shift_d[bit_q] = ~sync_data;
                    state_d        = HIGH;
                    phase_d        = '0;
                end
            end
            HIGH: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
                        state_d   = DONE;
                        buttons_d = shift_q;
                        pressed_d = shift_q & ~buttons_q;
                    end else begin
                        state_d = LOW;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Pad-facing and status outputs are decoded from the next state and
    // registered, so they are glitch-free and aligned with the state they
    // describe.
    always_comb begin
        latch_d = (state_d == LATCH);
        clk_d   = (state_d == HIGH);
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers. Reset aborts any transaction in flight
    // and returns everything to zero on the next cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            pressed_q <= '0;
            latch_q   <= 1'b0;
            clk_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            pressed_q <= pressed_d;
            latch_q   <= latch_d;
            clk_q     <= clk_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign chip_latch_out = latch_q;
    assign chip_clk_out   = clk_q;
    assign buttons_out    = buttons_q;
    assign pressed_out    = pressed_q;
    assign valid_out      = valid_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_controller_poller.sv
// ---------------------------------------------------------------------------
// tb_controller_poller
// Directed self-checking bench for controller_poller with HALF_CYCLES=4 and
// POLL_CYCLES=200. A behavioural pad model drives chip_data_raw from the
// latch and clock lines; expected button words are written by hand.
// ---------------------------------------------------------------------------
module tb_controller_poller;

    localparam int HALF = 4;
    localparam int POLL = 200;
    localparam int TXN  = 18 * HALF;

    typedef struct {
        int         startCyc;
        int         validCyc;
        int         latchLen;
        int         pulses;
        int         maxHigh;
        int         busyGaps;
        logic [7:0] buttons;
        logic [7:0] pressed;
        logic       postActive;
    } txn_t;

    logic       clk_in        = 1'b0;
    logic       rst_in        = 1'b1;
    logic       force_poll_in = 1'b0;
    logic       chip_data_raw;
    logic       chip_latch_out;
    logic       chip_clk_out;
    logic [7:0] buttons_out;
    logic [7:0] pressed_out;
    logic       valid_out;
    logic       busy_out;

    logic [7:0] padButtons = 8'h00;
    logic [3:0] padIdx     = 4'd0;
    logic       padClkPrev = 1'b0;

    int cyc        = 0;
    int relCyc     = 0;
    int errorCount = 0;
    int checkCount = 0;

    controller_poller #(
        .HALF_CYCLES (HALF),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .chip_data_raw  (chip_data_raw),
        .force_poll_in  (force_poll_in),
        .chip_latch_out (chip_latch_out),
        .chip_clk_out   (chip_clk_out),
        .buttons_out    (buttons_out),
        .pressed_out    (pressed_out),
        .valid_out      (valid_out),
        .busy_out       (busy_out)
    );

    // 100 MHz-style free-running clock
    always #5 clk_in = ~clk_in;

    // Cycle counter used to measure latencies and model the poll timer
    always @(posedge clk_in) cyc <= cyc + 1;

    // Pad model: latch reloads the shift position, each rising pad clock
    // advances it, and after the last button the line idles high.
    always @(posedge clk_in) begin
        if (chip_latch_out) begin
            padIdx <= 4'd0;
        end else if (chip_clk_out && !padClkPrev && !padIdx[3]) begin
            padIdx <= padIdx + 4'd1;
        end
        padClkPrev <= chip_clk_out;
    end

    assign chip_data_raw = padIdx[3] ? 1'b1 : ~padButtons[padIdx[2:0]];

    // Value the DUT poll timer holds at the current negedge
    function automatic int timerNow();
        return (cyc - relCyc) % POLL;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pad, input logic forcePoll);
        padButtons    = pad;
        force_poll_in = forcePoll;
    endtask

    // Waits for the next latch, follows the transaction to valid_out, then
    // steps one more cycle to see whether the DUT went back to idle.
    task automatic waitTransaction(output txn_t t);
        int   n;
        int   highRun;
        logic prevClk;
        t.startCyc = -1; t.validCyc = -1; t.latchLen = 0; t.pulses = 0;
        t.maxHigh = 0; t.busyGaps = 0; t.buttons = '0; t.pressed = '0;
        t.postActive = 1'b0;
        highRun = 0;
        prevClk = 1'b0;
        n = 0;
        while (chip_latch_out !== 1'b1 && n < 2 * POLL) begin
            @(negedge clk_in);
            n++;
        end
        if (chip_latch_out !== 1'b1) begin
            checkOutput("latchSeen", 32'(chip_latch_out), 32'd1);
            return;
        end
        t.startCyc = cyc;
        n = 0;
        while (valid_out !== 1'b1 && n < 2 * TXN) begin
            if (chip_latch_out) t.latchLen++;
            if (chip_clk_out) begin
                if (!prevClk) t.pulses++;
                highRun++;
                if (highRun > t.maxHigh) t.maxHigh = highRun;
            end else begin
                highRun = 0;
            end
            if (busy_out !== 1'b1) t.busyGaps++;
            prevClk = chip_clk_out;
            @(negedge clk_in);
            n++;
        end
        if (valid_out !== 1'b1) begin
            checkOutput("validSeen", 32'(valid_out), 32'd1);
            return;
        end
        t.validCyc = cyc;
        if (busy_out !== 1'b1) t.busyGaps++;
        t.buttons = buttons_out;
        t.pressed = pressed_out;
        @(negedge clk_in);
        t.postActive = valid_out | busy_out;
    endtask

    initial begin
        txn_t t;
        txn_t h [3];
        int   forceCyc;
        int   extra;
        int   n;

        $display("[TB] controller_poller bench starting");

        // Reset state, pad released
        applyStimulus(8'h00, 1'b0);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput("rstLatch",   32'(chip_latch_out), 32'd0);
        checkOutput("rstClk",     32'(chip_clk_out),   32'd0);
        checkOutput("rstBusy",    32'(busy_out),       32'd0);
        checkOutput("rstValid",   32'(valid_out),      32'd0);
        checkOutput("rstButtons", 32'(buttons_out),    32'd0);
        checkOutput("rstPressed", 32'(pressed_out),    32'd0);
        rst_in = 1'b0;
        relCyc = cyc;

        // First timer-driven poll, no buttons
        waitTransaction(t);
        checkOutput("t1Start",    t.startCyc - relCyc, POLL);
        checkOutput("t1Latency",  t.validCyc - t.startCyc, TXN);
        checkOutput("t1LatchLen", t.latchLen, 2 * HALF);
        checkOutput("t1Pulses",   t.pulses, 8);
        checkOutput("t1MaxHigh",  t.maxHigh, HALF);
        checkOutput("t1BusyGaps", t.busyGaps, 0);
        checkOutput("t1Buttons",  32'(t.buttons), 32'h00);
        checkOutput("t1Pressed",  32'(t.pressed), 32'h00);
        checkOutput("t1Post",     32'(t.postActive), 32'd0);

        // A + START + LEFT, then the same again
        applyStimulus(8'h49, 1'b1);
        @(negedge clk_in);
        applyStimulus(8'h49, 1'b0);
        waitTransaction(t);
        checkOutput("t2aButtons", 32'(t.buttons), 32'h49);
        checkOutput("t2aPressed", 32'(t.pressed), 32'h49);
        applyStimulus(8'h49, 1'b1);
        @(negedge clk_in);
        applyStimulus(8'h49, 1'b0);
        waitTransaction(t);
        checkOutput("t2bButtons", 32'(t.buttons), 32'h49);
        checkOutput("t2bPressed", 32'(t.pressed), 32'h00);

        // Change to UP only: releases must not show as pressed
        applyStimulus(8'h10, 1'b1);
        @(negedge clk_in);
        applyStimulus(8'h10, 1'b0);
        waitTransaction(t);
        checkOutput("t3Buttons", 32'(t.buttons), 32'h10);
        checkOutput("t3Pressed", 32'(t.pressed), 32'h10);

        // Reset during the LOW half of bit 3 (cycles 32..35 after latch)
        applyStimulus(8'h10, 1'b1);
        @(negedge clk_in);
        applyStimulus(8'h10, 1'b0);
        n = 0;
        while (chip_latch_out !== 1'b1 && n < 2 * POLL) begin
            @(negedge clk_in);
            n++;
        end
        repeat (33) @(negedge clk_in);
        checkOutput("t4PreClk",     32'(chip_clk_out), 32'd0);
        checkOutput("t4PreBusy",    32'(busy_out),     32'd1);
        checkOutput("t4PreButtons", 32'(buttons_out),  32'h10);
        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("t4Latch",   32'(chip_latch_out), 32'd0);
        checkOutput("t4Clk",     32'(chip_clk_out),   32'd0);
        checkOutput("t4Busy",    32'(busy_out),       32'd0);
        checkOutput("t4Valid",   32'(valid_out),      32'd0);
        checkOutput("t4Buttons", 32'(buttons_out),    32'd0);
        checkOutput("t4Pressed", 32'(pressed_out),    32'd0);
        rst_in = 1'b0;
        relCyc = cyc;
        extra = 0;
        n = 0;
        while (timerNow() != 50 && n < 2 * POLL) begin
            if (valid_out) extra++;
            @(negedge clk_in);
            n++;
        end
        checkOutput("t4NoValid", extra, 0);

        // Forced poll at timer=50 with a second request mid-transaction
        applyStimulus(8'h10, 1'b1);
        forceCyc = cyc;
        @(negedge clk_in);
        applyStimulus(8'h10, 1'b0);
        fork
            waitTransaction(t);
            begin
                repeat (20) @(negedge clk_in);
                force_poll_in = 1'b1;
                @(negedge clk_in);
                force_poll_in = 1'b0;
            end
        join
        checkOutput("t5Start",   t.startCyc - forceCyc, 1);
        checkOutput("t5Latency", t.validCyc - t.startCyc, TXN);
        checkOutput("t5Buttons", 32'(t.buttons), 32'h10);
        checkOutput("t5Pressed", 32'(t.pressed), 32'h10);
        extra = 0;
        repeat (60) begin
            @(negedge clk_in);
            if (valid_out) extra++;
        end
        checkOutput("t5Single", extra, 0);

        // Timer wrap and force in the same IDLE cycle: one transaction
        n = 0;
        while (timerNow() != POLL - 1 && n < 2 * POLL) begin
            @(negedge clk_in);
            n++;
        end
        applyStimulus(8'h81, 1'b1);
        forceCyc = cyc;
        @(negedge clk_in);
        applyStimulus(8'h81, 1'b0);
        waitTransaction(t);
        checkOutput("t6Start",   t.startCyc - forceCyc, 1);
        checkOutput("t6Buttons", 32'(t.buttons), 32'h81);
        checkOutput("t6Pressed", 32'(t.pressed), 32'h81);
        extra = 0;
        repeat (60) begin
            @(negedge clk_in);
            if (valid_out) extra++;
        end
        checkOutput("t6Single", extra, 0);

        // force_poll_in held high: back-to-back transactions
        applyStimulus(8'h81, 1'b1);
        for (int i = 0; i < 3; i++) begin
            waitTransaction(h[i]);
        end
        applyStimulus(8'h81, 1'b0);
        checkOutput("t7Gap1",     h[1].validCyc - h[0].validCyc, TXN + 2);
        checkOutput("t7Gap2",     h[2].validCyc - h[1].validCyc, TXN + 2);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t7MaxHigh", h[i].maxHigh, HALF);
            checkOutput("t7Post",    32'(h[i].postActive), 32'd0);
        end
        checkOutput("t7Buttons",  32'(h[2].buttons), 32'h81);
        checkOutput("t7Pressed",  32'(h[2].pressed), 32'h00);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    // Last-resort guard so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
